// File: rtl/seg_pkg.sv
// Shared types, constants and helpers for the 7-segment scanner.
// Exports SEG_OFF, cnt_w() counter-width helper and hex7() glyph table.
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // abcdefg, 1 = segment on
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] r;
    unique case (n)
      4'h0: r = 7'h7E;
      4'h1: r = 7'h30;
      4'h2: r = 7'h6D;
      4'h3: r = 7'h79;
      4'h4: r = 7'h33;
      4'h5: r = 7'h5B;
      4'h6: r = 7'h5F;
      4'h7: r = 7'h70;
      4'h8: r = 7'h7F;
      4'h9: r = 7'h7B;
      4'hA: r = 7'h77;
      4'hB: r = 7'h1F;
      4'hC: r = 7'h4E;
      4'hD: r = 7'h3D;
      4'hE: r = 7'h4F;
      4'hF: r = 7'h47;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Display bus between data source and scanner.
// master: drives data/masks/brightness/disp_en; slave: drives seg/an/frame_start.
interface seg_scan_mux_if #(
  parameter int DIGITS   = 4,
  parameter int BRIGHT_W = 4
);
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp_mask;
  logic [DIGITS-1:0]   blank_mask;
  logic                lz_suppress;
  logic [BRIGHT_W-1:0] brightness;
  logic                disp_en;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                frame_start;

  modport master (
    output data, dp_mask, blank_mask,
    output lz_suppress, brightness, disp_en,
    input  seg, an, frame_start
  );

  modport slave (
    input  data, dp_mask, blank_mask,
    input  lz_suppress, brightness, disp_en,
    output seg, an, frame_start
  );
endinterface

// File: rtl/seg_hex7_dec.sv
// Combinational nibble to abcdefg decoder (1 = segment on).
// Ports: nib_i (4b nibble), seg_o (7b abcdefg).
module seg_hex7_dec
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = hex7(nib_i);
endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode hex scanner with frame shadowing,
// masks, leading-zero blanking, PWM dimming and dead-time.
// Ports: clk, rst_n (async low), bus (seg_scan_mux_if.slave).
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SCAN_TICKS = 400000,
  parameter int DEAD_TICKS = 64,
  parameter int BRIGHT_W   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_mux_if.slave  bus
);
  localparam int SLOT_W = cnt_w(SCAN_TICKS);
  localparam int IDX_W  = cnt_w(DIGITS);

  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [IDX_W-1:0]    dig_q, dig_d;
  logic [BRIGHT_W-1:0] pwm_q, pwm_d;
  logic [4*DIGITS-1:0] data_sh_q;
  logic [DIGITS-1:0]   dp_sh_q, blank_sh_q;
  logic                lz_sh_q;
  logic                first_q;
  logic                fs_q, fs_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          seg_q, seg_d;

  logic              wrap, load, lit, zrun;
  logic [3:0]        nib;
  logic [6:0]        glyph;
  logic [DIGITS-1:0] lz_blank;

  assign wrap = (slot_q == SLOT_W'(SCAN_TICKS - 1));
  // first cycle after reset also reloads so the
  // opening frame never shows stale zeros
  assign load = first_q || (wrap && dig_q == '0);

  always_comb begin
    slot_d = wrap ? '0 : slot_q + 1'b1;
    dig_d  = dig_q;
    if (wrap)
      dig_d = (dig_q == '0) ? IDX_W'(DIGITS - 1)
                            : dig_q - 1'b1;
    pwm_d  = pwm_q + 1'b1;
    fs_d   = load;
  end

  // a digit is a leading zero if it and every
  // digit to its left hold zero; digit 0 is kept
  always_comb begin
    lz_blank = '0;
    zrun     = lz_sh_q;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zrun        = zrun && (data_sh_q[4*i +: 4] == 4'h0);
      lz_blank[i] = zrun;
    end
  end

  assign nib = 4'(data_sh_q >> {dig_q, 2'b00});

  seg_hex7_dec u_dec (
    .nib_i (nib),
    .seg_o (glyph)
  );

  always_comb begin
    lit = (slot_q >= SLOT_W'(DEAD_TICKS))
       && bus.disp_en
       && !blank_sh_q[dig_q]
       && !lz_blank[dig_q]
       && (pwm_q <= bus.brightness);
    an_d  = '1;
    seg_d = SEG_OFF;
    if (lit) begin
      an_d  = ~(DIGITS'(1) << dig_q);
      seg_d = ~{glyph, dp_sh_q[dig_q]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q     <= '0;
      dig_q      <= IDX_W'(DIGITS - 1);
      pwm_q      <= '0;
      data_sh_q  <= '0;
      dp_sh_q    <= '0;
      blank_sh_q <= '0;
      lz_sh_q    <= 1'b0;
      first_q    <= 1'b1;
      fs_q       <= 1'b0;
      an_q       <= '1;
      seg_q      <= SEG_OFF;
    end else begin
      slot_q  <= slot_d;
      dig_q   <= dig_d;
      pwm_q   <= pwm_d;
      first_q <= 1'b0;
      fs_q    <= fs_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      if (load) begin
        data_sh_q  <= bus.data;
        dp_sh_q    <= bus.dp_mask;
        blank_sh_q <= bus.blank_mask;
        lz_sh_q    <= bus.lz_suppress;
      end
    end
  end

  assign bus.seg         = seg_q;
  assign bus.an          = an_q;
  assign bus.frame_start = fs_q;

endmodule
